msi_cache_ctrl: RTL and testbench
=================================

Name: msi_cache_ctrl

Overview:
- Parametrised direct-mapped private cache with MSI snooping coherence; successor to the fixed two-line cache node with its 2-bit state, 3-bit address and 4-bit data.
- Sits between one processor request port and the shared snooping bus; the other caches and main memory sit on that bus.
- Adds the following over the two-line node: configurable line count, tag compare, write-back of Modified victims, bus request/acknowledge handshake, snoop-driven state changes and flush.

Parameters:
- LINES, 4, number of cache lines; power of two, ≥2; IDX_W = log2(LINES).
- ADDR_W, 3, address width; must be > IDX_W; TAG_W = ADDR_W-IDX_W.
- DATA_W, 4, width of one line (one word per line).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  processor request.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  request address; index=req_addr[IDX_W-1:0], tag=upper bits.
- req_wdata  in  DATA_W  write data.
- req_ready  out  1  request accepted when req_valid&req_ready.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  read data (line data after a write).
- resp_hit  out  1  1 if completed without a bus transaction.
- bus_req  out  1  bus transaction request.
- bus_op  out  2  01=BusRd, 10=BusRdX, 11=WriteBack.
- bus_addr  out  ADDR_W  transaction address.
- bus_wdata  out  DATA_W  write-back data.
- bus_ack  in  1  one-cycle completion; for BusRd/BusRdX, bus_rdata is valid this cycle.
- bus_rdata  in  DATA_W  fill data.
- snoop_valid  in  1  another node's transaction on the bus.
- snoop_op  in  2  01=BusRd, 10=BusRdX; other codes are ignored.
- snoop_addr  in  ADDR_W  snooped address.
- snoop_flush  out  1  registered; pulses one cycle after a snoop hit on a Modified line.
- snoop_data  out  DATA_W  flushed data, valid with snoop_flush.
- probe_idx  in  IDX_W  debug line select.
- probe_state  out  2  combinational state of probed line: 00=I, 01=S, 10=M.
- probe_tag  out  TAG_W  tag of probed line.
- probe_data  out  DATA_W  data of probed line.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All lines I, tags 0, data 0.
  - FSM goes to IDLE.
  - bus_req, resp_valid, resp_hit, snoop_flush are 0; all data/address outputs are 0.
  - Reset in mid-transaction aborts it; bus_req drops immediately, with no response.
- FSM states: IDLE, LOOKUP, WRBACK, FILL, RESP.
- Request acceptance:
  - req_ready = (state==IDLE) & ~snoop_valid.
  - On acceptance, the request is latched and the FSM moves to LOOKUP.
- LOOKUP: hit = (line.state!=I) & (tag match).
  - Read hit: resp_valid next cycle with line data, resp_hit=1; state unchanged. Total latency is 2 cycles from acceptance.
  - Write hit on M: update data at the LOOKUP edge; resp next cycle, resp_hit=1.
  - Write hit on S: go to FILL with BusRdX (upgrade).
  - Miss where the victim is M with a different tag: go to WRBACK.
  - Any other miss: go to FILL. Read uses BusRd; write uses BusRdX.
- WRBACK:
  - Drive bus_req=1, op=11, bus_addr={victim tag, index}, bus_wdata=victim data.
  - All held stable until bus_ack.
  - On bus_ack: victim becomes I and the FSM goes to FILL.
- FILL:
  - Drive bus_req=1, op=BusRd or BusRdX, bus_addr=latched req_addr; held until bus_ack.
  - On bus_ack: write tag, and data (bus_rdata for a read; req_wdata for a write).
  - State after a read fill is S; after a write fill it is M.
  - Then go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle with resp_hit=0 and resp_rdata = the new line data.
  - Return to IDLE.
- bus_req deasserts the cycle after bus_ack unless the FSM moves into the next bus phase.
- Snoop handling:
  - Applies in every FSM state; a snoop hit requires a tag match and state!=I.
  - M+BusRd: go to S; flush.
  - M+BusRdX: go to I; flush.
  - S+BusRdX: go to I.
  - S+BusRd and I: no change.
- Snoop priority: a snoop update to a line takes priority over a same-cycle FSM update of that line.
- Snoop invalidates the victim while in WRBACK before bus_ack: cancel the write-back (drop bus_req the next cycle) and go to FILL. The snoop flush already supplied the data.
- Snoop during FILL that hits the old line: applied normally. The fill then overwrites the line.
- Snoops carry no backpressure and are processed every cycle.
- resp_valid has no backpressure.

Test Plan:
- After reset, read 3'b101 with bus_ack and bus_rdata=4'hA two cycles later:
  - BusRd issued with addr 3'b101.
  - RESP gives rdata=A, hit=0.
  - probe_idx=1 shows S, tag 2'b10.
- Re-read 3'b101:
  - No bus_req.
  - resp_valid 2 cycles after acceptance, rdata=A, hit=1.
- Write 4'h5 to 3'b101 (line in S):
  - BusRdX issued.
  - After ack the line is M with data=5, resp hit=0.
  - A further write of 4'h6 hits with no bus activity.
- With line 1 in M (tag 10, data 6), read 3'b001:
  - WriteBack issued with addr 3'b101, wdata=6.
  - BusRd for 3'b001 follows.
  - Final state S, tag 00.
- Snoops on line 1 in M with data 6:
  - snoop BusRd 3'b101 gives snoop_flush=1, snoop_data=6 the next cycle, state S.
  - A subsequent snoop BusRdX gives I with no flush.
- Snoop during write-back, and reset mid-fill:
  - snoop BusRdX on the victim during WRBACK cancels the write-back; FILL proceeds.
  - reset_n=0 mid-FILL drops bus_req immediately; all lines read I.

Source files
------------

// File: rtl/msi_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : msi_cache_ctrl
// Purpose  : Direct-mapped private cache node with MSI snooping coherence.
//            One processor request port on one side, the shared snooping
//            bus on the other. Dirty victims are written back before a
//            refill. Snooped BusRd/BusRdX transactions downgrade or
//            invalidate lines and flush Modified data.
// Ports    : clock, reset_n            - clock, async active-low reset
//            req_*                     - processor request (valid/ready)
//            resp_*                    - one-cycle completion pulse
//            bus_req/op/addr/wdata     - outgoing bus transaction
//            bus_ack/rdata             - bus completion and fill data
//            snoop_valid/op/addr       - other nodes' bus transactions
//            snoop_flush/data          - registered flush of Modified data
//            probe_idx/state/tag/data  - debug view of one line
// Revision : 1.0 - initial release
// ============================================================================
module msi_cache_ctrl #(
  parameter  int LINES  = 4,
  parameter  int ADDR_W = 3,
  parameter  int DATA_W = 4,
  localparam int IDX_W  = $clog2(LINES),
  localparam int TAG_W  = ADDR_W - IDX_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              bus_req,
  output logic [1:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              snoop_valid,
  input  logic [1:0]        snoop_op,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_flush,
  output logic [DATA_W-1:0] snoop_data,
  input  logic [IDX_W-1:0]  probe_idx,
  output logic [1:0]        probe_state,
  output logic [TAG_W-1:0]  probe_tag,
  output logic [DATA_W-1:0] probe_data
);

  localparam logic [1:0] LS_I   = 2'b00;
  localparam logic [1:0] LS_S   = 2'b01;
  localparam logic [1:0] LS_M   = 2'b10;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_RDX = 2'b10;
  localparam logic [1:0] OP_WB  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_WRBACK = 3'd2,
    ST_FILL   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  // Line storage
  logic [1:0]        r_lstate [LINES];
  logic [TAG_W-1:0]  r_tag    [LINES];
  logic [DATA_W-1:0] r_data   [LINES];

  // Latched request and response registers
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic              r_hit, w_hit_nxt;
  // One-cycle bus silence after a write-back is cancelled by a snoop
  logic              r_gap, w_gap_nxt;
  logic              r_flush;
  logic [DATA_W-1:0] r_flush_data;

  // Request-line view
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [1:0]        w_cur_state;
  logic [TAG_W-1:0]  w_cur_tag;
  logic [DATA_W-1:0] w_cur_data;

  assign w_idx       = r_addr[IDX_W-1:0];
  assign w_tag       = r_addr[ADDR_W-1:IDX_W];
  assign w_cur_state = r_lstate[w_idx];
  assign w_cur_tag   = r_tag[w_idx];
  assign w_cur_data  = r_data[w_idx];

  // Snoop decode
  logic [IDX_W-1:0] w_sn_idx;
  logic [TAG_W-1:0] w_sn_tag;
  logic [1:0]       w_sn_state;
  logic             w_sn_hit;
  logic             w_sn_upd;
  logic [1:0]       w_sn_new;
  logic             w_sn_flush;
  logic             w_sn_same;

  assign w_sn_idx   = snoop_addr[IDX_W-1:0];
  assign w_sn_tag   = snoop_addr[ADDR_W-1:IDX_W];
  assign w_sn_state = r_lstate[w_sn_idx];
  assign w_sn_hit   = snoop_valid && (snoop_op == OP_RD || snoop_op == OP_RDX) &&
                      (w_sn_state != LS_I) && (r_tag[w_sn_idx] == w_sn_tag);

  always_comb begin
    w_sn_upd   = 1'b0;
    w_sn_new   = w_sn_state;
    w_sn_flush = 1'b0;
    if (w_sn_hit) begin
      if (w_sn_state == LS_M) begin
        w_sn_upd   = 1'b1;
        w_sn_flush = 1'b1;
        w_sn_new   = (snoop_op == OP_RD) ? LS_S : LS_I;
      end else if (snoop_op == OP_RDX) begin
        w_sn_upd = 1'b1;
        w_sn_new = LS_I;
      end
    end
  end

  // Snoop touching the line the FSM is working on this cycle
  assign w_sn_same = w_sn_upd && (w_sn_idx == w_idx);

  // LOOKUP decides on the post-snoop state so that a same-cycle downgrade
  // (e.g. M->S) turns a write hit into an upgrade instead of a silent write.
  logic [1:0] w_eff_state;
  logic       w_lookup_hit;
  assign w_eff_state  = w_sn_same ? w_sn_new : w_cur_state;
  assign w_lookup_hit = (w_eff_state != LS_I) && (w_cur_tag == w_tag);

  assign req_ready = (r_state == ST_IDLE) && !snoop_valid;

  // FSM next-state, line update and bus drive
  logic              w_line_we;
  logic [1:0]        w_line_st;
  logic [TAG_W-1:0]  w_line_tag;
  logic [DATA_W-1:0] w_line_data;

  always_comb begin
    w_state_nxt = r_state;
    w_line_we   = 1'b0;
    w_line_st   = w_cur_state;
    w_line_tag  = w_cur_tag;
    w_line_data = w_cur_data;
    w_rdata_nxt = r_rdata;
    w_hit_nxt   = r_hit;
    w_gap_nxt   = 1'b0;
    bus_req     = 1'b0;
    bus_op      = 2'b00;
    bus_addr    = '0;
    bus_wdata   = '0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid && req_ready) w_state_nxt = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (w_lookup_hit && !r_write) begin
          w_state_nxt = ST_RESP;
          w_rdata_nxt = w_cur_data;
          w_hit_nxt   = 1'b1;
        end else if (w_lookup_hit && w_eff_state == LS_M) begin
          w_line_we   = 1'b1;
          w_line_data = r_wdata;
          w_state_nxt = ST_RESP;
          w_rdata_nxt = r_wdata;
          w_hit_nxt   = 1'b1;
        end else if (!w_lookup_hit && w_eff_state == LS_M) begin
          // Valid M line with a different tag: dirty victim
          w_state_nxt = ST_WRBACK;
        end else begin
          // Clean miss, or write hit on S needing an upgrade
          w_state_nxt = ST_FILL;
        end
      end
      ST_WRBACK: begin
        bus_req   = 1'b1;
        bus_op    = OP_WB;
        bus_addr  = {w_cur_tag, w_idx};
        bus_wdata = w_cur_data;
        if (bus_ack) begin
          w_line_we   = 1'b1;
          w_line_st   = LS_I;
          w_state_nxt = ST_FILL;
        end else if (w_sn_same && w_sn_new == LS_I) begin
          // Snooper took ownership and our flush already carried the data
          w_state_nxt = ST_FILL;
          w_gap_nxt   = 1'b1;
        end
      end
      ST_FILL: begin
        if (!r_gap) begin
          bus_req  = 1'b1;
          bus_op   = r_write ? OP_RDX : OP_RD;
          bus_addr = r_addr;
          if (bus_ack) begin
            w_line_we   = 1'b1;
            w_line_st   = r_write ? LS_M : LS_S;
            w_line_tag  = w_tag;
            w_line_data = r_write ? r_wdata : bus_rdata;
            w_rdata_nxt = w_line_data;
            w_hit_nxt   = 1'b0;
            w_state_nxt = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_hit        <= 1'b0;
      r_gap        <= 1'b0;
      r_flush      <= 1'b0;
      r_flush_data <= '0;
      for (int i = 0; i < LINES; i++) begin
        r_lstate[i] <= LS_I;
        r_tag[i]    <= '0;
        r_data[i]   <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_rdata <= w_rdata_nxt;
      r_hit   <= w_hit_nxt;
      r_gap   <= w_gap_nxt;
      r_flush <= w_sn_flush;
      if (w_sn_flush) r_flush_data <= r_data[w_sn_idx];
      if (req_valid && req_ready) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_sn_upd) r_lstate[w_sn_idx] <= w_sn_new;
      // A snoop on the same line this cycle wins over the FSM write
      if (w_line_we && !w_sn_same) begin
        r_lstate[w_idx] <= w_line_st;
        r_tag[w_idx]    <= w_line_tag;
        r_data[w_idx]   <= w_line_data;
      end
    end
  end

  assign resp_valid  = (r_state == ST_RESP);
  assign resp_hit    = (r_state == ST_RESP) && r_hit;
  assign resp_rdata  = r_rdata;
  assign snoop_flush = r_flush;
  assign snoop_data  = r_flush_data;
  assign probe_state = r_lstate[probe_idx];
  assign probe_tag   = r_tag[probe_idx];
  assign probe_data  = r_data[probe_idx];

endmodule
`default_nettype wire

// File: tb/tb_msi_cache_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_msi_cache_ctrl
// Purpose  : Directed self-checking bench for msi_cache_ctrl (2 lines,
//            3-bit address, 4-bit data). Expected bus transactions and
//            responses are queued before each request and popped as the
//            DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msi_cache_ctrl;

  localparam int LINES  = 2;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 4;
  localparam int IDX_W  = 1;
  localparam int TAG_W  = 2;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_hit;
  logic              bus_req;
  logic [1:0]        bus_op;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack = 1'b0;
  logic [DATA_W-1:0] bus_rdata = '0;
  logic              snoop_valid = 1'b0;
  logic [1:0]        snoop_op = 2'b00;
  logic [ADDR_W-1:0] snoop_addr = '0;
  logic              snoop_flush;
  logic [DATA_W-1:0] snoop_data;
  logic [IDX_W-1:0]  probe_idx = '0;
  logic [1:0]        probe_state;
  logic [TAG_W-1:0]  probe_tag;
  logic [DATA_W-1:0] probe_data;

  always #5 clock = ~clock;

  msi_cache_ctrl #(.LINES(LINES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .bus_req(bus_req), .bus_op(bus_op), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_addr(snoop_addr),
    .snoop_flush(snoop_flush), .snoop_data(snoop_data),
    .probe_idx(probe_idx), .probe_state(probe_state), .probe_tag(probe_tag),
    .probe_data(probe_data)
  );

  typedef struct {
    logic [1:0] op;
    logic [2:0] addr;
    logic [3:0] wdata;
    logic [3:0] rdata;
    bit         cancel;   // inject a BusRdX snoop on this write-back instead of acking
  } bus_t;

  typedef struct {
    logic [3:0] rdata;
    logic       hit;
    int         lat;      // negedge index of resp_valid after acceptance, -1 = any
  } resp_t;

  bus_t  bus_q[$];
  resp_t resp_q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_bus(input logic [1:0] op, input logic [2:0] addr,
                         input logic [3:0] wdata, input logic [3:0] rdata, input bit cancel);
    bus_t b;
    b.op = op; b.addr = addr; b.wdata = wdata; b.rdata = rdata; b.cancel = cancel;
    bus_q.push_back(b);
  endtask

  task automatic exp_resp(input logic [3:0] rdata, input logic hit, input int lat);
    resp_t r;
    r.rdata = rdata; r.hit = hit; r.lat = lat;
    resp_q.push_back(r);
  endtask

  task automatic chk_probe(input string name, input logic idx, input logic [1:0] st,
                           input logic [1:0] tag, input logic [3:0] data);
    probe_idx = idx;
    #1;
    check({name, " state"}, probe_state, st);
    check({name, " tag"}, probe_tag, tag);
    check({name, " data"}, probe_data, data);
  endtask

  task automatic do_req(input string name, input logic wr, input logic [2:0] addr,
                        input logic [3:0] wdata);
    bit         done;
    bit         gap_chk;
    logic [3:0] gap_data;
    int         waited;
    bus_t       b;
    resp_t      r;
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    waited = 0;
    @(negedge clock);
    while (!req_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    check({name, " accept"}, req_ready, 1);
    @(posedge clock); #1 req_valid = 1'b0;
    done = 0; gap_chk = 0; gap_data = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clock);
      if (gap_chk) begin
        check({name, " cancelled wb drops bus_req"}, bus_req, 0);
        check({name, " cancel flush"}, {snoop_flush, snoop_data}, {1'b1, gap_data});
        gap_chk = 0;
      end else if (bus_req) begin
        if (bus_q.size() == 0) begin
          check({name, " unexpected bus_req"}, bus_req, 0);
          done = 1;
        end else begin
          b = bus_q.pop_front();
          check({name, " bus_op"}, bus_op, b.op);
          check({name, " bus_addr"}, bus_addr, b.addr);
          if (b.op == 2'b11) check({name, " bus_wdata"}, bus_wdata, b.wdata);
          if (b.cancel) begin
            snoop_valid = 1'b1; snoop_op = 2'b10; snoop_addr = b.addr;
            gap_chk = 1; gap_data = b.wdata;
          end else begin
            bus_ack = 1'b1; bus_rdata = b.rdata;
          end
        end
      end
      if (resp_valid && !done) begin
        if (resp_q.size() == 0) begin
          check({name, " unexpected resp_valid"}, resp_valid, 0);
        end else begin
          r = resp_q.pop_front();
          check({name, " resp_rdata"}, resp_rdata, r.rdata);
          check({name, " resp_hit"}, resp_hit, r.hit);
          if (r.lat >= 0) check({name, " resp latency"}, c, r.lat);
        end
        done = 1;
      end
      @(posedge clock); #1;
      bus_ack = 1'b0; bus_rdata = '0; snoop_valid = 1'b0;
    end
    check({name, " completed in budget"}, done, 1);
    check({name, " bus ops consumed"}, bus_q.size(), 0);
    bus_q.delete();
    @(negedge clock);
    check({name, " resp single pulse"}, resp_valid, 0);
  endtask

  task automatic do_snoop(input string name, input logic [1:0] op, input logic [2:0] addr,
                          input logic exp_flush, input logic [3:0] exp_data);
    @(posedge clock); #1;
    snoop_valid = 1'b1; snoop_op = op; snoop_addr = addr;
    @(negedge clock);
    check({name, " req_ready blocked"}, req_ready, 0);
    @(posedge clock); #1 snoop_valid = 1'b0;
    @(negedge clock);
    check({name, " snoop_flush"}, snoop_flush, exp_flush);
    if (exp_flush) check({name, " snoop_data"}, snoop_data, exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    // ---------------- reset ----------------
    #12;
    check("rst bus_req", bus_req, 0);
    check("rst resp_valid", resp_valid, 0);
    check("rst resp_hit", resp_hit, 0);
    check("rst snoop_flush", snoop_flush, 0);
    check("rst bus_addr/op/wdata", {bus_addr, bus_op, bus_wdata}, 0);
    check("rst resp_rdata/snoop_data", {resp_rdata, snoop_data}, 0);
    chk_probe("rst line0", 1'b0, 2'b00, 2'b00, 4'h0);
    chk_probe("rst line1", 1'b1, 2'b00, 2'b00, 4'h0);
    @(negedge clock); reset_n = 1'b1;
    check("idle req_ready", req_ready, 1);

    // ---------------- read miss / hit ----------------
    exp_bus(2'b01, 3'b101, 4'h0, 4'hA, 0);
    exp_resp(4'hA, 1'b0, -1);
    do_req("rd101 miss", 1'b0, 3'b101, 4'h0);
    chk_probe("after rd miss", 1'b1, 2'b01, 2'b10, 4'hA);

    exp_resp(4'hA, 1'b1, 1);
    do_req("rd101 hit", 1'b0, 3'b101, 4'h0);

    // ---------------- write upgrade / write hit ----------------
    exp_bus(2'b10, 3'b101, 4'h0, 4'hF, 0);
    exp_resp(4'h5, 1'b0, -1);
    do_req("wr5 upgrade", 1'b1, 3'b101, 4'h5);
    chk_probe("after upgrade", 1'b1, 2'b10, 2'b10, 4'h5);

    exp_resp(4'h6, 1'b1, 1);
    do_req("wr6 hitM", 1'b1, 3'b101, 4'h6);
    chk_probe("after hitM", 1'b1, 2'b10, 2'b10, 4'h6);

    // ---------------- dirty victim write-back ----------------
    exp_bus(2'b11, 3'b101, 4'h6, 4'h0, 0);
    exp_bus(2'b01, 3'b001, 4'h0, 4'h3, 0);
    exp_resp(4'h3, 1'b0, -1);
    do_req("rd001 wb", 1'b0, 3'b001, 4'h0);
    chk_probe("after wb fill", 1'b1, 2'b01, 2'b00, 4'h3);

    // clean S victim with different tag: no write-back
    exp_bus(2'b10, 3'b101, 4'h0, 4'hF, 0);
    exp_resp(4'h6, 1'b0, -1);
    do_req("wr6 clean miss", 1'b1, 3'b101, 4'h6);
    chk_probe("after clean miss", 1'b1, 2'b10, 2'b10, 4'h6);

    // ---------------- snoops ----------------
    do_snoop("snp rd M", 2'b01, 3'b101, 1'b1, 4'h6);
    chk_probe("after snp rd", 1'b1, 2'b01, 2'b10, 4'h6);
    do_snoop("snp rdx tag miss", 2'b10, 3'b001, 1'b0, 4'h0);
    chk_probe("after snp tag miss", 1'b1, 2'b01, 2'b10, 4'h6);
    do_snoop("snp rdx S", 2'b10, 3'b101, 1'b0, 4'h0);
    chk_probe("after snp rdx", 1'b1, 2'b00, 2'b10, 4'h6);

    // ---------------- snoop cancels write-back ----------------
    exp_bus(2'b10, 3'b101, 4'h0, 4'hF, 0);
    exp_resp(4'h7, 1'b0, -1);
    do_req("wr7 miss", 1'b1, 3'b101, 4'h7);
    chk_probe("after wr7", 1'b1, 2'b10, 2'b10, 4'h7);

    exp_bus(2'b11, 3'b101, 4'h7, 4'h0, 1);
    exp_bus(2'b01, 3'b001, 4'h0, 4'h9, 0);
    exp_resp(4'h9, 1'b0, -1);
    do_req("rd001 wb cancel", 1'b0, 3'b001, 4'h0);
    chk_probe("after cancel fill", 1'b1, 2'b01, 2'b00, 4'h9);

    // ---------------- reset during FILL ----------------
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'b110; req_wdata = 4'h0;
    @(negedge clock);
    check("midfill accept", req_ready, 1);
    @(posedge clock); #1 req_valid = 1'b0;
    waited = 0;
    @(negedge clock);
    while (!bus_req && waited < 10) begin
      @(negedge clock);
      waited++;
    end
    check("midfill bus_req up", bus_req, 1);
    check("midfill bus_op", bus_op, 2'b01);
    #2 reset_n = 1'b0;
    #1;
    check("midfill reset bus_req", bus_req, 0);
    check("midfill reset resp_valid", resp_valid, 0);
    chk_probe("midfill rst line0", 1'b0, 2'b00, 2'b00, 4'h0);
    chk_probe("midfill rst line1", 1'b1, 2'b00, 2'b00, 4'h0);
    @(negedge clock); reset_n = 1'b1;

    exp_bus(2'b01, 3'b101, 4'h0, 4'hB, 0);
    exp_resp(4'hB, 1'b0, -1);
    do_req("rd101 after reset", 1'b0, 3'b101, 4'h0);
    chk_probe("after reset fill", 1'b1, 2'b01, 2'b10, 4'hB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
